dmem_responder: RTL and testbench

//  Data-memory responder on the far side of the MEM-stage load/store interface.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 148 ++++++++++++++
 tb/tb_dmem_responder.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// MEM-stage load/store bus between the pipeline (master) and the data-memory responder (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready; req_* must be stable while req_valid is high and req_ready low.
interface dmem_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall_o;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3,
      input  req_ready, resp_valid, resp_rdata, resp_err, stall_o
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3,
      output req_ready, resp_valid, resp_rdata, resp_err, stall_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM with RISC-V byte/half/word lane handling and a fixed-latency response.
// One request in flight; o_dbg_state exposes the FSM (0 = IDLE, 1 = BUSY).
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic  clk,
   input  logic  rst,
   dmem_if.slave io_bus,
   output logic  o_dbg_state
);
   localparam int AW = $clog2(DEPTH_WORDS);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam bit LAT1 = (LATENCY == 1);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

   state_t         r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic           r_resp_valid;
   logic           r_err;
   logic [31:0]    r_rdata;
   logic [31:0]    r_mem [DEPTH_WORDS];

   logic           w_accept;
   logic           w_done;
   logic           w_err;
   logic           w_store;
   logic [1:0]     w_off;
   logic [AW-1:0]  w_idx;
   logic [3:0]     w_be;
   logic [31:0]    w_wlanes;
   logic [31:0]    w_word;
   logic [7:0]     w_byte;
   logic [15:0]    w_half;
   logic [31:0]    w_load;

   assign io_bus.req_ready  = (r_state == S_IDLE);
   assign io_bus.stall_o    = io_bus.req_valid & ~io_bus.req_ready;
   assign io_bus.resp_valid = r_resp_valid;
   assign io_bus.resp_rdata = r_resp_valid ? r_rdata : 32'h0;
   assign io_bus.resp_err   = r_resp_valid & r_err;
   assign o_dbg_state       = r_state;

   // A request coinciding with reset is never taken.
   assign w_accept = io_bus.req_valid & io_bus.req_ready & ~rst;
   assign w_off    = io_bus.req_addr[1:0];
   assign w_idx    = io_bus.req_addr[AW+1:2];
   assign w_store  = w_accept & io_bus.req_we & ~w_err;

   always_comb begin
      w_err    = 1'b0;
      w_be     = 4'b0000;
      w_wlanes = io_bus.req_wdata;
      case (io_bus.req_funct3)
         3'b000: begin
            w_be     = 4'b0001 << w_off;
            w_wlanes = {4{io_bus.req_wdata[7:0]}};
         end
         3'b001: begin
            w_err    = w_off[0];
            w_be     = w_off[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{io_bus.req_wdata[15:0]}};
         end
         3'b010: begin
            w_err = |w_off;
            w_be  = 4'b1111;
         end
         3'b100:  w_err = io_bus.req_we;
         3'b101:  w_err = io_bus.req_we | w_off[0];
         default: w_err = 1'b1;
      endcase
   end

   always_comb begin
      w_word = r_mem[w_idx];
      w_byte = w_word[{w_off, 3'b000} +: 8];
      w_half = w_word[{w_off[1], 4'b0000} +: 16];
      case (io_bus.req_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b100:  w_load = {24'h0, w_byte};
         3'b101:  w_load = {16'h0, w_half};
         default: w_load = w_word;
      endcase
      if (w_err || io_bus.req_we) begin
         w_load = 32'h0;
      end
   end

   // RAM has no reset so committed stores survive a pipeline reset.
   always_ff @(posedge clk) begin
      if (w_store) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (LAT1) begin
                  w_done = 1'b1;
               end else begin
                  w_state_nxt = S_BUSY;
                  w_cnt_nxt   = CW'(LATENCY - 1);
               end
            end
         end
         S_BUSY: begin
            // Count of 1 means this edge closes the last busy cycle.
            if (r_cnt == CW'(1)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
               w_done      = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - CW'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_resp_valid <= 1'b0;
         r_err        <= 1'b0;
         r_rdata      <= 32'h0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_resp_valid <= w_done;
         if (w_accept) begin
            r_err   <= w_err;
            r_rdata <= w_load;
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a byte-addressed reference memory.
module tb_dmem_responder;
   localparam int DEPTH_WORDS = 1024;
   localparam int LATENCY     = 2;
   localparam int NBYTES      = DEPTH_WORDS * 4;

   logic clk = 1'b0;
   logic rst;
   logic dbg_state;

   dmem_if bus ();

   dmem_responder #(.DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)) dut (
      .clk         (clk),
      .rst         (rst),
      .io_bus      (bus),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  mb [NBYTES];
   logic [31:0] exp_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: memory is a flat byte array; accesses are little-endian and wrap modulo its size.
   task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] f3, output logic e_err, output logic [31:0] e_rd);
      int unsigned base;
      int unsigned size;
      logic [31:0] v;
      base = addr % NBYTES;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      e_err = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) || ((addr % size) != 0);
      e_rd  = 32'h0;
      if (!e_err) begin
         if (we) begin
            for (int i = 0; i < int'(size); i++) mb[base + i] = wdata[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < int'(size); i++) v = v | (32'(mb[base + i]) << (8 * i));
            if (size == 4 || f3[2]) e_rd = v;
            else if (size == 1) e_rd = {{24{v[7]}}, v[7:0]};
            else e_rd = {{16{v[15]}}, v[15:0]};
         end
      end
   endtask

   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] f3, input string tag, output logic [31:0] obs_rd);
      logic        e_err;
      logic [31:0] e_rd;
      int          n;
      ref_access(we, addr, wdata, f3, e_err, e_rd);
      obs_rd = 32'h0;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_funct3 = f3;
      #1;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         chk({tag, "_accept_timeout"}, 32'(bus.req_ready), 32'h1);
         bus.req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_wdata = $urandom;
      bus.req_addr  = $urandom;
      n = 1;
      while (!bus.resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(LATENCY));
      obs_rd = bus.resp_rdata;
      chk({tag, "_rdata"}, bus.resp_rdata, e_rd);
      chk({tag, "_err"}, 32'(bus.resp_err), 32'(e_err));
      @(negedge clk);
      chk({tag, "_pulse_end"}, 32'(bus.resp_valid), 32'h0);
      chk({tag, "_rdata_clr"}, bus.resp_rdata, 32'h0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] a [3];
      logic        e_err;
      logic [31:0] e_rd;
      logic [2:0]  f3_pool [8];
      bit          exp_resp;

      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.req_funct3 = 3'd2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(bus.req_ready), 32'h1);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
      chk("rst_rdata", bus.resp_rdata, 32'h0);
      chk("rst_err", 32'(bus.resp_err), 32'h0);
      chk("rst_stall", 32'(bus.stall_o), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 32; i++) do_req(1'b1, 32'(4 * i), $urandom, 3'd2, "init_sw", rd);

      // Store, then word load back.
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw_10", rd);
      do_req(1'b0, 32'h10, 32'h0, 3'd2, "lw_10", rd);
      chk("lw_deadbeef", rd, 32'hDEADBEEF);

      // Byte store into lane 3 and extension variants.
      do_req(1'b1, 32'h13, 32'h00000080, 3'd0, "sb_13", rd);
      do_req(1'b0, 32'h13, 32'h0, 3'd0, "lb_13", rd);
      chk("lb_sext", rd, 32'hFFFFFF80);
      do_req(1'b0, 32'h13, 32'h0, 3'd4, "lbu_13", rd);
      chk("lbu_zext", rd, 32'h00000080);
      do_req(1'b0, 32'h10, 32'h0, 3'd2, "lw_10b", rd);
      chk("lw_merged", rd, 32'h80ADBEEF);
      do_req(1'b0, 32'h12, 32'h0, 3'd5, "lhu_12", rd);
      chk("lhu_zext", rd, 32'h000080AD);

      // Error cases leave memory untouched.
      do_req(1'b0, 32'h12, 32'h0, 3'd2, "lw_mis", rd);
      do_req(1'b1, 32'h11, 32'h0000FFFF, 3'd1, "sh_mis", rd);
      do_req(1'b0, 32'h10, 32'h0, 3'd3, "f3_011", rd);
      do_req(1'b1, 32'h10, 32'h0, 3'd4, "sbu_ill", rd);
      do_req(1'b0, 32'h10, 32'h0, 3'd2, "lw_after_err", rd);
      chk("lw_unchanged", rd, 32'h80ADBEEF);

      // Back-to-back loads with req_valid held.
      a[0] = 32'h10; a[1] = 32'h14; a[2] = 32'h18;
      for (int i = 0; i < 3; i++) begin
         ref_access(1'b0, a[i], 32'h0, 3'd2, e_err, e_rd);
         exp_q.push_back(e_rd);
      end
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'd2;
      bus.req_addr   = a[0];
      for (int cyc = 0; cyc < 8; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (cyc == 1) bus.req_addr = a[1];
         if (cyc == 3) bus.req_addr = a[2];
         if (cyc == 5) bus.req_valid = 1'b0;
         #1;
         if (cyc <= 4) begin
            chk($sformatf("b2b_ready_c%0d", cyc), 32'(bus.req_ready), 32'((cyc % 2) == 0));
            chk($sformatf("b2b_stall_c%0d", cyc), 32'(bus.stall_o), 32'((cyc % 2) == 1));
         end
         exp_resp = (cyc == 2) || (cyc == 4) || (cyc == 6);
         chk($sformatf("b2b_resp_c%0d", cyc), 32'(bus.resp_valid), 32'(exp_resp));
         if (bus.resp_valid) begin
            if (exp_q.size() == 0) chk("b2b_extra_resp", 32'h1, 32'h0);
            else chk($sformatf("b2b_rdata_c%0d", cyc), bus.resp_rdata, exp_q.pop_front());
         end
      end
      chk("b2b_all_resp", 32'(exp_q.size()), 32'h0);

      // Randomized traffic over the initialised region, with random upper address bits.
      f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};
      for (int i = 0; i < 80; i++) begin
         do_req(1'($urandom_range(0, 1)), ($urandom << 12) | 32'($urandom_range(0, 127)),
                $urandom, f3_pool[$urandom_range(0, 7)], $sformatf("rnd%0d", i), rd);
      end

      // Reset while a load is pending discards its response.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b0;
      bus.req_addr   = 32'h10;
      bus.req_funct3 = 3'd2;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("mid_busy_state", 32'(dbg_state), 32'h1);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i == 2) rst = 1'b0;
         @(negedge clk);
         chk($sformatf("mid_rst_no_resp%0d", i), 32'(bus.resp_valid), 32'h0);
      end
      chk("mid_rst_ready", 32'(bus.req_ready), 32'h1);

      // Request presented during reset is not taken.
      @(negedge clk);
      rst            = 1'b1;
      bus.req_valid  = 1'b1;
      bus.req_we     = 1'b1;
      bus.req_addr   = 32'h20;
      bus.req_wdata  = 32'h12345678;
      bus.req_funct3 = 3'd2;
      @(negedge clk);
      @(negedge clk);
      chk("rst_req_state", 32'(dbg_state), 32'h0);
      rst           = 1'b0;
      bus.req_valid = 1'b0;
      do_req(1'b0, 32'h20, 32'h0, 3'd2, "lw_after_rst_req", rd);

      // Address wraps modulo the RAM size.
      do_req(1'b1, 32'(NBYTES), 32'hCAFEF00D, 3'd2, "sw_wrap", rd);
      do_req(1'b0, 32'h0, 32'h0, 3'd2, "lw_wrap", rd);
      chk("wrap_value", rd, 32'hCAFEF00D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
